// File: rtl/marker_pkg.sv
// Shared widths, colour thresholds and FSM encodings for marker_tracker.
// Build option SMOOTH_EN is consumed by marker_tracker.sv.
package marker_pkg;

  localparam int H_RES      = 1280;
  localparam int V_RES      = 1024;
  localparam int SUM_W      = 32;
  localparam int CNT_W      = 21;
  localparam int COORD_W    = 12;
  localparam int MIN_PIXELS = 16;

  localparam logic [3:0] R_MIN = 4'hC;
  localparam logic [3:0] G_MAX = 4'h4;
  localparam logic [3:0] B_MAX = 4'h4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DIVIDE  = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic logic [COORD_W-1:0] sat_inc(
    input logic [COORD_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/marker_tracker_if.sv
// Camera pixel stream bundle: qualifier, framing flags and RGB444 data.
// The camera side drives it (master); the tracker samples it (slave).
interface marker_tracker_if;
  import marker_pkg::*;

  logic        pix_valid;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;
  logic [11:0] pix_rgb;

  modport master (
    output pix_valid,
    output pix_sof,
    output pix_eol,
    output pix_eof,
    output pix_rgb
  );

  modport slave (
    input pix_valid,
    input pix_sof,
    input pix_eol,
    input pix_eof,
    input pix_rgb
  );

endinterface

// File: rtl/marker_tracker_seq_divider.sv
// Restoring divider, one quotient bit per cycle; done is high during the
// final iteration, so the quotient is settled on the following cycle.
module seq_divider
  import marker_pkg::*;
#(
  parameter int OUT_W = SUM_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [SUM_W-1:0]   dividend,
  input  logic [CNT_W-1:0]   divisor,
  output logic               done,
  output logic [OUT_W-1:0]   quotient
);

  localparam logic [5:0] ITER = 6'(SUM_W);

  logic [SUM_W-1:0] q;
  logic [CNT_W-1:0] dvs;
  logic [CNT_W-1:0] rem;
  logic [CNT_W:0]   trial;
  logic [5:0]       left;
  logic             ge;

  // q shifts dividend bits out at the top and quotient bits in at the bottom
  assign trial    = {rem, q[SUM_W-1]};
  assign ge       = trial >= {1'b0, dvs};
  assign done     = left == 6'd1;
  assign quotient = q[OUT_W-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q    <= '0;
      dvs  <= '0;
      rem  <= '0;
      left <= '0;
    end else if (start) begin
      q    <= dividend;
      dvs  <= divisor;
      rem  <= '0;
      left <= ITER;
    end else if (left != '0) begin
      q    <= {q[SUM_W-2:0], ge};
      rem  <= CNT_W'(ge ? trial - {1'b0, dvs} : trial);
      left <= left - 1'b1;
    end
  end

endmodule

// File: rtl/marker_tracker.sv
// Colour-marker centroid tracker: per-frame sums, then sequential division.
// Build option SMOOTH_EN averages each found result with the previous one.
module marker_tracker
  import marker_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  marker_tracker_if.slave    pix,
  output logic [COORD_W-1:0] X_position,
  output logic [COORD_W-1:0] Y_position,
  output logic               coord_valid,
  output logic               marker_found,
  output logic               busy
);

  rgb_t               px;
  logic               match;
  logic               take;
  logic               eof;
  logic               start;
  logic               done_x;
  logic               done_y;
  logic               found_q;
  logic [1:0]         state;
  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic [COORD_W-1:0] q_x;
  logic [COORD_W-1:0] q_y;
  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;
  logic [SUM_W-1:0]   sum_x;
  logic [SUM_W-1:0]   sum_y;
  logic [SUM_W-1:0]   acc_x;
  logic [SUM_W-1:0]   acc_y;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   acc_c;

  assign px    = pix.pix_rgb;
  assign match = px.r >= R_MIN && px.g <= G_MAX && px.b <= B_MAX;
  assign take  = pix.pix_valid && match;
  assign eof   = pix.pix_valid && pix.pix_eof;
  assign pos_x = pix.pix_sof ? '0 : x_cnt;
  assign pos_y = pix.pix_sof ? '0 : y_cnt;
  assign busy  = state == ST_DIVIDE;

  // acc_* is the frame total including the current pixel
  always_comb begin
    acc_x = pix.pix_sof ? '0 : sum_x;
    acc_y = pix.pix_sof ? '0 : sum_y;
    acc_c = pix.pix_sof ? '0 : cnt;
    if (take) begin
      acc_x = acc_x + SUM_W'(pos_x);
      acc_y = acc_y + SUM_W'(pos_y);
      if (acc_c != '1) acc_c = acc_c + 1'b1;
    end
  end

  assign start = eof && state == ST_IDLE &&
                 acc_c >= CNT_W'(MIN_PIXELS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_cnt <= '0;
      y_cnt <= '0;
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (pix.pix_valid) begin
      x_cnt <= pix.pix_eol ? '0 : sat_inc(pos_x);
      y_cnt <= pix.pix_eol ? sat_inc(pos_y) : pos_y;
      sum_x <= pix.pix_eof ? '0 : acc_x;
      sum_y <= pix.pix_eof ? '0 : acc_y;
      cnt   <= pix.pix_eof ? '0 : acc_c;
    end
  end

  seq_divider #(.OUT_W(COORD_W)) u_div_x (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .dividend (acc_x),
    .divisor  (acc_c),
    .done     (done_x),
    .quotient (q_x)
  );

  seq_divider #(.OUT_W(COORD_W)) u_div_y (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .dividend (acc_y),
    .divisor  (acc_c),
    .done     (done_y),
    .quotient (q_y)
  );

`ifdef SMOOTH_EN
  logic [COORD_W:0] avg_x;
  logic [COORD_W:0] avg_y;

  assign avg_x = {1'b0, X_position} + {1'b0, q_x};
  assign avg_y = {1'b0, Y_position} + {1'b0, q_y};
  // a fresh marker (none in the previous result) loads directly
  assign nx = marker_found ? COORD_W'(avg_x >> 1) : q_x;
  assign ny = marker_found ? COORD_W'(avg_y >> 1) : q_y;
`else
  assign nx = q_x;
  assign ny = q_y;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      found_q      <= 1'b0;
      coord_valid  <= 1'b0;
      marker_found <= 1'b0;
      X_position   <= '0;
      Y_position   <= '0;
    end else begin
      coord_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (eof) begin
            found_q <= start;
            state   <= start ? ST_DIVIDE : ST_PUBLISH;
          end
        end
        ST_DIVIDE: begin
          if (done_x && done_y) state <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          coord_valid  <= 1'b1;
          marker_found <= found_q;
          if (found_q) begin
            X_position <= nx;
            Y_position <= ny;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_marker_tracker.sv
// Randomised scenario bench for marker_tracker with a frame-level model.
// Build option SMOOTH_EN must match the RTL build.
module tb_marker_tracker;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] X_position;
  logic [11:0] Y_position;
  logic        coord_valid;
  logic        marker_found;
  logic        busy;

  marker_tracker_if pix();

  marker_tracker dut (
    .clk          (clk),
    .resetn       (resetn),
    .pix          (pix),
    .X_position   (X_position),
    .Y_position   (Y_position),
    .coord_valid  (coord_valid),
    .marker_found (marker_found),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int pq_cyc[$];
  int pq_x[$];
  int pq_y[$];
  int pq_f[$];

  always @(negedge clk) begin
    if (coord_valid) begin
      pq_cyc.push_back(cyc);
      pq_x.push_back(int'(X_position));
      pq_y.push_back(int'(Y_position));
      pq_f.push_back(int'(marker_found));
    end
  end

  int     m_x = 0;
  int     m_y = 0;
  int     m_f = 0;
  int     m_lat = 0;
  int     eof_cyc = 0;
  longint fsx;
  longint fsy;
  int     fcnt;

  // Frame-level reference: centroid of matched pixels, optional averaging
  function automatic void model_publish();
    int qx;
    int qy;
    if (fcnt >= 16) begin
      qx = int'(fsx / fcnt) & 4095;
      qy = int'(fsy / fcnt) & 4095;
`ifdef SMOOTH_EN
      if (m_f == 1) begin
        qx = (m_x + qx) / 2;
        qy = (m_y + qy) / 2;
      end
`endif
      m_x = qx;
      m_y = qy;
      m_f = 1;
      m_lat = 34;
    end else begin
      m_f = 0;
      m_lat = 2;
    end
  endfunction

  task automatic send_frame(input int w, input int h, input int rows,
                            input int bx0, input int bx1,
                            input int by0, input int by1,
                            input bit noise);
    logic [11:0] c;
    bit blk;
    fsx = 0;
    fsy = 0;
    fcnt = 0;
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < w; x++) begin
        if (noise && $urandom_range(7) == 0) begin
          @(negedge clk);
          pix.pix_valid = 1'b0;
          {pix.pix_sof, pix.pix_eol, pix.pix_eof} = 3'($urandom);
          pix.pix_rgb = 12'hF00;
        end
        blk = x >= bx0 && x <= bx1 && y >= by0 && y <= by1;
        if (blk)
          c = {4'($urandom_range(15, 12)), 4'($urandom_range(4, 0)),
               4'($urandom_range(4, 0))};
        else if (!noise)
          c = 12'h000;
        else if ($urandom_range(1) == 1)
          c = {4'($urandom_range(15, 11)), 4'($urandom_range(6, 3)),
               4'($urandom_range(6, 3))};
        else
          c = 12'($urandom);
        @(negedge clk);
        pix.pix_valid = 1'b1;
        pix.pix_sof = (x == 0 && y == 0);
        pix.pix_eol = (x == w - 1);
        pix.pix_eof = (x == w - 1 && y == h - 1);
        pix.pix_rgb = c;
        if (pix.pix_eof) eof_cyc = cyc;
        if (c[11:8] >= 4'd12 && c[7:4] <= 4'd4 && c[3:0] <= 4'd4) begin
          fsx += x;
          fsy += y;
          fcnt++;
        end
      end
    end
    @(negedge clk);
    pix.pix_valid = 1'b0;
    pix.pix_sof = 1'b0;
    pix.pix_eol = 1'b0;
    pix.pix_eof = 1'b0;
    pix.pix_rgb = '0;
  endtask

  task automatic test_reset();
    pix.pix_valid = 1'b0;
    pix.pix_sof = 1'b0;
    pix.pix_eol = 1'b0;
    pix.pix_eof = 1'b0;
    pix.pix_rgb = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (X_position !== 12'd0) begin n_bad++; $display("FAIL reset_x: got %0d want 0", X_position); end
    n_cmp++; if (Y_position !== 12'd0) begin n_bad++; $display("FAIL reset_y: got %0d want 0", Y_position); end
    n_cmp++; if (coord_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", coord_valid); end
    n_cmp++; if (marker_found !== 1'b0) begin n_bad++; $display("FAIL reset_found: got %0b want 0", marker_found); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
  endtask

  task automatic test_centroid();
    int b;
    b = pq_cyc.size();
    send_frame(110, 210, 210, 100, 109, 200, 209, 1'b0);
    model_publish();
    repeat (50) @(negedge clk);
    n_cmp++; if (pq_cyc.size() - b !== 1) begin n_bad++; $display("FAIL centroid_pulses: got %0d want 1", pq_cyc.size() - b); end
    if (pq_cyc.size() > b) begin
      n_cmp++; if (pq_cyc[b] - eof_cyc !== 34) begin n_bad++; $display("FAIL centroid_latency: got %0d want 34", pq_cyc[b] - eof_cyc); end
      n_cmp++; if (pq_x[b] !== 104) begin n_bad++; $display("FAIL centroid_x: got %0d want 104", pq_x[b]); end
      n_cmp++; if (pq_y[b] !== 204) begin n_bad++; $display("FAIL centroid_y: got %0d want 204", pq_y[b]); end
      n_cmp++; if (pq_f[b] !== 1) begin n_bad++; $display("FAIL centroid_found: got %0d want 1", pq_f[b]); end
    end
  endtask

  task automatic test_no_marker(input int side, input string tag);
    int b;
    b = pq_cyc.size();
    if (side > 0) send_frame(24, 12, 12, 4, 3 + side, 2, 1 + side, 1'b0);
    else send_frame(24, 12, 12, -1, -1, -1, -1, 1'b0);
    model_publish();
    repeat (50) @(negedge clk);
    n_cmp++; if (pq_cyc.size() - b !== 1) begin n_bad++; $display("FAIL %s_pulses: got %0d want 1", tag, pq_cyc.size() - b); end
    if (pq_cyc.size() > b) begin
      n_cmp++; if (pq_cyc[b] - eof_cyc !== 2) begin n_bad++; $display("FAIL %s_latency: got %0d want 2", tag, pq_cyc[b] - eof_cyc); end
      n_cmp++; if (pq_f[b] !== 0) begin n_bad++; $display("FAIL %s_found: got %0d want 0", tag, pq_f[b]); end
      n_cmp++; if (pq_x[b] !== m_x) begin n_bad++; $display("FAIL %s_x_held: got %0d want %0d", tag, pq_x[b], m_x); end
      n_cmp++; if (pq_y[b] !== m_y) begin n_bad++; $display("FAIL %s_y_held: got %0d want %0d", tag, pq_y[b], m_y); end
    end
  endtask

  task automatic test_cutoff();
    int b;
    b = pq_cyc.size();
    send_frame(40, 30, 15, 5, 14, 5, 14, 1'b0);
    send_frame(40, 30, 30, 20, 29, 10, 19, 1'b0);
    model_publish();
    repeat (50) @(negedge clk);
    n_cmp++; if (pq_cyc.size() - b !== 1) begin n_bad++; $display("FAIL cutoff_pulses: got %0d want 1", pq_cyc.size() - b); end
    if (pq_cyc.size() > b) begin
      n_cmp++; if (pq_x[b] !== m_x) begin n_bad++; $display("FAIL cutoff_x: got %0d want %0d", pq_x[b], m_x); end
      n_cmp++; if (pq_y[b] !== m_y) begin n_bad++; $display("FAIL cutoff_y: got %0d want %0d", pq_y[b], m_y); end
      n_cmp++; if (pq_cyc[b] - eof_cyc !== 34) begin n_bad++; $display("FAIL cutoff_latency: got %0d want 34", pq_cyc[b] - eof_cyc); end
    end
  endtask

  task automatic test_back_to_back();
    int b;
    int a_eof;
    int ax;
    int ay;
    b = pq_cyc.size();
    send_frame(30, 20, 20, 5, 12, 6, 13, 1'b0);
    model_publish();
    a_eof = eof_cyc;
    ax = m_x;
    ay = m_y;
    send_frame(5, 5, 5, 0, 4, 0, 4, 1'b0);
    send_frame(20, 12, 12, 9, 14, 2, 8, 1'b0);
    model_publish();
    repeat (50) @(negedge clk);
    n_cmp++; if (pq_cyc.size() - b !== 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 2", pq_cyc.size() - b); end
    if (pq_cyc.size() > b + 1) begin
      n_cmp++; if (pq_cyc[b] - a_eof !== 34) begin n_bad++; $display("FAIL b2b_latency: got %0d want 34", pq_cyc[b] - a_eof); end
      n_cmp++; if (pq_x[b] !== ax) begin n_bad++; $display("FAIL b2b_x: got %0d want %0d", pq_x[b], ax); end
      n_cmp++; if (pq_y[b] !== ay) begin n_bad++; $display("FAIL b2b_y: got %0d want %0d", pq_y[b], ay); end
      n_cmp++; if (pq_x[b+1] !== m_x) begin n_bad++; $display("FAIL b2b_next_x: got %0d want %0d", pq_x[b+1], m_x); end
      n_cmp++; if (pq_y[b+1] !== m_y) begin n_bad++; $display("FAIL b2b_next_y: got %0d want %0d", pq_y[b+1], m_y); end
    end
  endtask

  task automatic test_random();
    int b;
    int w;
    int h;
    int s;
    int bx;
    int by;
    for (int i = 0; i < 8; i++) begin
      w = $urandom_range(64, 24);
      h = $urandom_range(40, 16);
      s = $urandom_range(8, 1);
      bx = $urandom_range(w - s);
      by = $urandom_range(h - s);
      b = pq_cyc.size();
      send_frame(w, h, h, bx, bx + s - 1, by, by + s - 1, 1'b1);
      model_publish();
      repeat (50) @(negedge clk);
      n_cmp++; if (pq_cyc.size() - b !== 1) begin n_bad++; $display("FAIL rand_pulses: frame %0d got %0d want 1", i, pq_cyc.size() - b); end
      if (pq_cyc.size() > b) begin
        n_cmp++; if (pq_cyc[b] - eof_cyc !== m_lat) begin n_bad++; $display("FAIL rand_latency: frame %0d got %0d want %0d", i, pq_cyc[b] - eof_cyc, m_lat); end
        n_cmp++; if (pq_f[b] !== m_f) begin n_bad++; $display("FAIL rand_found: frame %0d got %0d want %0d", i, pq_f[b], m_f); end
        n_cmp++; if (pq_x[b] !== m_x) begin n_bad++; $display("FAIL rand_x: frame %0d got %0d want %0d", i, pq_x[b], m_x); end
        n_cmp++; if (pq_y[b] !== m_y) begin n_bad++; $display("FAIL rand_y: frame %0d got %0d want %0d", i, pq_y[b], m_y); end
      end
    end
  endtask

`ifdef SMOOTH_EN
  task automatic test_smooth();
    int b;
    b = pq_cyc.size();
    send_frame(30, 20, 20, 6, 14, 6, 14, 1'b0);
    model_publish();
    send_frame(30, 20, 20, 16, 24, 6, 14, 1'b0);
    model_publish();
    repeat (50) @(negedge clk);
    n_cmp++; if (pq_cyc.size() - b !== 2) begin n_bad++; $display("FAIL smooth_pulses: got %0d want 2", pq_cyc.size() - b); end
    if (pq_cyc.size() > b + 1) begin
      n_cmp++; if (pq_x[b] !== 10) begin n_bad++; $display("FAIL smooth_first_x: got %0d want 10", pq_x[b]); end
      n_cmp++; if (pq_x[b+1] !== 15) begin n_bad++; $display("FAIL smooth_second_x: got %0d want 15", pq_x[b+1]); end
      n_cmp++; if (pq_y[b+1] !== m_y) begin n_bad++; $display("FAIL smooth_second_y: got %0d want %0d", pq_y[b+1], m_y); end
    end
  endtask
`endif

  task automatic test_reset_divide();
    int b;
    send_frame(30, 20, 20, 3, 10, 3, 10, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstdiv_busy: got %0b want 1", busy); end
    b = pq_cyc.size();
    resetn = 1'b0;
    #1;
    n_cmp++; if (X_position !== 12'd0) begin n_bad++; $display("FAIL rstdiv_x: got %0d want 0", X_position); end
    n_cmp++; if (Y_position !== 12'd0) begin n_bad++; $display("FAIL rstdiv_y: got %0d want 0", Y_position); end
    n_cmp++; if (marker_found !== 1'b0) begin n_bad++; $display("FAIL rstdiv_found: got %0b want 0", marker_found); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstdiv_busy_clr: got %0b want 0", busy); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    n_cmp++; if (pq_cyc.size() - b !== 0) begin n_bad++; $display("FAIL rstdiv_pulses: got %0d want 0", pq_cyc.size() - b); end
    m_x = 0;
    m_y = 0;
    m_f = 0;
  endtask

  initial begin
    test_reset();
    test_centroid();
    test_no_marker(0, "black");
    test_no_marker(3, "small");
`ifdef SMOOTH_EN
    test_smooth();
`endif
    test_cutoff();
    test_back_to_back();
    test_random();
    test_reset_divide();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
